mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Parametrised multicycle control unit for the multicycle CPU datapath, the successor to the fixed-timing `CU`. It sequences IF/ID/EXE/MEM/WB per instruction and drives the existing datapath select and write-enable signals. It adds req/ack handshakes so instruction and data memories may insert wait states, a memory-timeout watchdog, a HALT instruction and retired-instruction and cycle counters. It sits between `IM`/`DM` and the `PC`, `RF`, `ALU`, `EXT` and mux instances in `multicycle_CPU`.

## Interface
- `CNT_W`, 32, width of `instr_count` and `cycle_count`.
- `TIMEOUT`, 15, maximum wait cycles for an ack, minimum 1.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `op_instruction`  in  6  opcode field from `IM`.
- `func_instruction`  in  6  func field from `IM`.
- `zero`  in  1  ALU zero flag.
- `im_ack`  in  1  instruction fetch complete; `op`/`func` are valid this cycle.
- `dm_ack`  in  1  data access complete; read data is valid this cycle.
- `w_pc`, `slc_ALUA`, `slc_ALUB`, `w_RF`, `w_dataMem`  out  1 each  datapath controls.
- `slc_RFWriteData`  out  2  write-back data select: 00 ALU, 01 DM, 10 PC+4.
- `op_ext`  out  2  extend type: 00 sa zero-extend, 01 zero-extend, 11 sign-extend.
- `slc_pcSrc`  out  2  next-PC select: 00 PC+4, 01 branch target, 10 rs, 11 jump target.
- `slc_RFWriteAddr`  out  2  RF write-address select: 00 $31, 01 rt, 10 rd.
- `op_ALU`  out  4  ALU operation: 0000 add, 0001 sub, 0011 or, 0100 and, 0101 slt.
- `im_req`, `dm_req`  out  1 each  memory requests.
- `halted`, `mem_err`, `illegal`  out  1 each  status outputs.
- `instr_count`, `cycle_count`  out  `CNT_W` each  counters.

## Operation
- **States:** IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101.
- **Instruction latch:** `op`/`func` are captured into internal registers on the IF edge where `im_ack`=1. All decode uses the latched copy.
- **Decoded instructions:**
  - R-type (op 000000): add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000.
  - I-type: addiu 001001, andi 001100, ori 001101, slti 001010, lw 100011, sw 101011, beq 000100, bne 000101.
  - J-type: j 000010, jal 000011.
  - halt: 111111.
- **IF:** `im_req`=1. Move to ID on `im_ack`; otherwise stay.
- **ID:**
  - j: pulse `w_pc` with `slc_pcSrc`=11, then IF.
  - jal: same PC update, plus `w_RF`=1 with addr 00 and data 10 in the same cycle, then IF.
  - jr: pulse `w_pc` with `slc_pcSrc`=10, then IF.
  - halt: go to HALT.
  - Undecoded opcode or func: `illegal` pulses for 1 cycle, `w_pc` with 00 (treated as a NOP), then IF.
  - All others: go to EXE.
- **EXE:**
  - ALU input selects and `op_ALU` are held for the instruction class. `slc_ALUA`=1 (rs). `slc_ALUB`=1 for immediates.
  - `op_ext` is 11 for addiu, slti, lw, sw, beq and bne; 01 for andi and ori.
  - beq/bne: `op_ALU`=0001. `w_pc`=1 with `slc_pcSrc`=01 if taken (beq: `zero`=1; bne: `zero`=0), else 00. Then IF.
  - lw/sw: `op_ALU`=0000, then MEM.
  - Others: go to WB.
- **MEM:**
  - `dm_req`=1; for sw, `w_dataMem`=1 for the whole MEM stay. EXE selects are held.
  - On `dm_ack`: sw pulses `w_pc` (00) and goes to IF; lw goes to WB.
- **WB:**
  - `w_RF`=1 and `w_pc`=1 (00) for one cycle, then IF.
  - `slc_RFWriteAddr` is 10 for R-type and 01 for I-type.
  - `slc_RFWriteData` is 01 for lw and 00 otherwise.
  - EXE selects are held.
- **Watchdog:** a wait counter resets on entry to IF or MEM. If it reaches `TIMEOUT` without an ack, `mem_err` is set (sticky) and the FSM goes to HALT.
- **HALT:** absorbing; every control output is 0. `halted`=1. Only `reset` leaves it.
- **`instr_count`:** increments on each edge where `w_pc`=1.
- **`cycle_count`:** increments every cycle while not in HALT.
- Both counters wrap modulo 2^`CNT_W`.

## Timing
- **Reset:**
  - While `reset`=1, the state is forced to IF, counters and flags clear, and every output is 0 (including `im_req`).
  - The first `im_req` is asserted in the cycle after `reset` falls.
  - Reset mid-instruction aborts it immediately; no partial write pulse may follow.
- **Write strobes:** `w_pc`, `w_RF` and `illegal` are exactly 1-cycle pulses. `w_RF` and `w_pc` in WB coincide.
- **Zero-wait latencies** (ack in the first request cycle):
  - j, jr, jal, illegal: 2 cycles.
  - beq/bne: 3 cycles.
  - R/I ALU ops: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- **Wait states:** each wait cycle adds 1 to the latency.
- **Handshake:** request stays high until the ack cycle inclusive and drops the next cycle. An ack without a request is ignored.
- **Timeout:** with `TIMEOUT`=N, the error is taken on the Nth consecutive cycle with no ack. An ack in that same cycle wins.
- **Branch decision:** `zero` is sampled combinationally in EXE only.

## Test plan
- Reset, then add $3,$1,$2 with immediate acks → `im_req` at cycle 1; `w_RF`=1 with `slc_RFWriteAddr`=10 at cycle 4; `instr_count`=1.
- lw with `dm_ack` delayed 3 cycles → `dm_req` held 4 cycles; `w_RF` with `slc_RFWriteData`=01 occurs 8 cycles after fetch start.
- beq with `zero`=1, then bne with `zero`=1 → `slc_pcSrc`=01, then 00; each `w_pc` is a single pulse.
- jal → in one ID cycle, `w_RF`=1, `slc_RFWriteAddr`=00, `slc_RFWriteData`=10, `slc_pcSrc`=11.
- `im_ack` never asserted with `TIMEOUT`=15 → `mem_err`=1 and `halted`=1 after 15 cycles; `cycle_count` then freezes.
- Opcode 111111 → HALT with all outputs 0. Asserting `reset` mid-MEM of an sw drops `w_dataMem` asynchronously.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm - multicycle CPU control unit.
//
// Sequences IF/ID/EXE/MEM/WB for each instruction and drives the datapath
// select and write-enable lines of multicycle_CPU. Instruction and data
// memory may add wait states through req/ack handshakes. A watchdog halts the
// machine with a sticky mem_err if an ack does not arrive in time. A HALT
// opcode parks the FSM until reset. Retired-instruction and cycle counters
// are provided.
//
// Handshake: im_req (in IF) and dm_req (in MEM) are held high up to and
// including the cycle in which the matching ack is seen. They drop in the
// following cycle because the FSM has moved on. An ack seen while no request
// is outstanding is ignored.
//
// Ports
//   CLK, reset                  clock, async active-high reset
//   op_instruction[5:0]         opcode field from IM
//   func_instruction[5:0]       func field from IM
//   zero                        ALU zero flag (branch decision, EXE only)
//   im_ack, dm_ack              memory completion acks
//   w_pc, w_RF, w_dataMem       write enables
//   slc_ALUA, slc_ALUB          ALU operand selects
//   slc_RFWriteData[1:0]        00 ALU, 01 DM, 10 PC+4
//   op_ext[1:0]                 00 sa zext, 01 zext, 11 sext
//   slc_pcSrc[1:0]              00 PC+4, 01 branch, 10 rs, 11 jump
//   slc_RFWriteAddr[1:0]        00 $31, 01 rt, 10 rd
//   op_ALU[3:0]                 0000 add, 0001 sub, 0011 or, 0100 and, 0101 slt
//   im_req, dm_req              memory requests
//   halted, mem_err, illegal    status
//   instr_count, cycle_count    counters, wrap modulo 2^CNT_W
//   state_dbg[2:0]              current FSM state, for debug and checkers
module mc_ctrl_fsm #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [5:0]       op_instruction,
  input  logic [5:0]       func_instruction,
  input  logic             zero,
  input  logic             im_ack,
  input  logic             dm_ack,
  output logic             w_pc,
  output logic             slc_ALUA,
  output logic             slc_ALUB,
  output logic             w_RF,
  output logic             w_dataMem,
  output logic [1:0]       slc_RFWriteData,
  output logic [1:0]       op_ext,
  output logic [1:0]       slc_pcSrc,
  output logic [1:0]       slc_RFWriteAddr,
  output logic [3:0]       op_ALU,
  output logic             im_req,
  output logic             dm_req,
  output logic             halted,
  output logic             mem_err,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_t;

  typedef enum logic [4:0] {
    K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_JR,
    K_ADDIU, K_ANDI, K_ORI, K_SLTI, K_LW, K_SW, K_BEQ, K_BNE,
    K_J, K_JAL, K_HALT, K_BAD
  } kind_t;

  localparam int WT = $clog2(TIMEOUT + 1);
  // Value the wait counter holds during the TIMEOUT-th consecutive wait cycle.
  localparam logic [WT-1:0] WAIT_LAST = WT'(TIMEOUT - 1);

  state_t        state, state_next;
  kind_t         kind;
  logic [5:0]    op_q, func_q;
  logic [WT-1:0] wait_cnt;
  logic          timeout;
  logic          alu_b, is_rtype;
  logic [1:0]    ext_sel;
  logic [3:0]    alu_op;

  assign state_dbg = state;

  // Decode from the latched opcode/func only; the IM bus may change after IF.
  always_comb begin
    kind = K_BAD;
    unique case (op_q)
      6'b000000: begin
        unique case (func_q)
          6'b100000: kind = K_ADD;
          6'b100010: kind = K_SUB;
          6'b100100: kind = K_AND;
          6'b100101: kind = K_OR;
          6'b101010: kind = K_SLT;
          6'b001000: kind = K_JR;
          default:   kind = K_BAD;
        endcase
      end
      6'b001001: kind = K_ADDIU;
      6'b001100: kind = K_ANDI;
      6'b001101: kind = K_ORI;
      6'b001010: kind = K_SLTI;
      6'b100011: kind = K_LW;
      6'b101011: kind = K_SW;
      6'b000100: kind = K_BEQ;
      6'b000101: kind = K_BNE;
      6'b000010: kind = K_J;
      6'b000011: kind = K_JAL;
      6'b111111: kind = K_HALT;
      default:   kind = K_BAD;
    endcase
  end

  // ALU operand/extend/operation selection, held from EXE through WB.
  always_comb begin
    alu_b    = 1'b0;
    ext_sel  = 2'b00;
    alu_op   = 4'b0000;
    is_rtype = 1'b0;
    unique case (kind)
      K_ADD:   begin alu_op = 4'b0000; is_rtype = 1'b1; end
      K_SUB:   begin alu_op = 4'b0001; is_rtype = 1'b1; end
      K_AND:   begin alu_op = 4'b0100; is_rtype = 1'b1; end
      K_OR:    begin alu_op = 4'b0011; is_rtype = 1'b1; end
      K_SLT:   begin alu_op = 4'b0101; is_rtype = 1'b1; end
      K_ADDIU: begin alu_b = 1'b1; ext_sel = 2'b11; alu_op = 4'b0000; end
      K_ANDI:  begin alu_b = 1'b1; ext_sel = 2'b01; alu_op = 4'b0100; end
      K_ORI:   begin alu_b = 1'b1; ext_sel = 2'b01; alu_op = 4'b0011; end
      K_SLTI:  begin alu_b = 1'b1; ext_sel = 2'b11; alu_op = 4'b0101; end
      K_LW,
      K_SW:    begin alu_b = 1'b1; ext_sel = 2'b11; alu_op = 4'b0000; end
      K_BEQ,
      K_BNE:   begin ext_sel = 2'b11; alu_op = 4'b0001; end
      default: ;
    endcase
  end

  // Next state and outputs. Everything is forced low while reset is high so
  // an aborted instruction cannot leave a partial write strobe behind.
  always_comb begin
    state_next      = state;
    timeout         = 1'b0;
    w_pc            = 1'b0;
    slc_ALUA        = 1'b0;
    slc_ALUB        = 1'b0;
    w_RF            = 1'b0;
    w_dataMem       = 1'b0;
    slc_RFWriteData = 2'b00;
    op_ext          = 2'b00;
    slc_pcSrc       = 2'b00;
    slc_RFWriteAddr = 2'b00;
    op_ALU          = 4'b0000;
    im_req          = 1'b0;
    dm_req          = 1'b0;
    halted          = 1'b0;
    illegal         = 1'b0;
    if (!reset) begin
      unique case (state)
        S_IF: begin
          im_req = 1'b1;
          if (im_ack) begin
            state_next = S_ID;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout    = 1'b1;
            state_next = S_HALT;
          end
        end
        S_ID: begin
          unique case (kind)
            K_J: begin
              w_pc       = 1'b1;
              slc_pcSrc  = 2'b11;
              state_next = S_IF;
            end
            K_JAL: begin
              w_pc            = 1'b1;
              slc_pcSrc       = 2'b11;
              w_RF            = 1'b1;
              slc_RFWriteAddr = 2'b00;
              slc_RFWriteData = 2'b10;
              state_next      = S_IF;
            end
            K_JR: begin
              w_pc       = 1'b1;
              slc_pcSrc  = 2'b10;
              state_next = S_IF;
            end
            K_HALT: state_next = S_HALT;
            K_BAD: begin
              // Unknown encoding retires as a NOP.
              illegal    = 1'b1;
              w_pc       = 1'b1;
              state_next = S_IF;
            end
            default: state_next = S_EXE;
          endcase
        end
        S_EXE: begin
          slc_ALUA = 1'b1;
          slc_ALUB = alu_b;
          op_ext   = ext_sel;
          op_ALU   = alu_op;
          unique case (kind)
            K_BEQ: begin
              w_pc       = 1'b1;
              slc_pcSrc  = zero ? 2'b01 : 2'b00;
              state_next = S_IF;
            end
            K_BNE: begin
              w_pc       = 1'b1;
              slc_pcSrc  = zero ? 2'b00 : 2'b01;
              state_next = S_IF;
            end
            K_LW, K_SW: state_next = S_MEM;
            default:    state_next = S_WB;
          endcase
        end
        S_MEM: begin
          slc_ALUA  = 1'b1;
          slc_ALUB  = alu_b;
          op_ext    = ext_sel;
          op_ALU    = alu_op;
          dm_req    = 1'b1;
          w_dataMem = (kind == K_SW);
          if (dm_ack) begin
            if (kind == K_SW) begin
              w_pc       = 1'b1;
              state_next = S_IF;
            end else begin
              state_next = S_WB;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            timeout    = 1'b1;
            state_next = S_HALT;
          end
        end
        S_WB: begin
          slc_ALUA        = 1'b1;
          slc_ALUB        = alu_b;
          op_ext          = ext_sel;
          op_ALU          = alu_op;
          w_RF            = 1'b1;
          w_pc            = 1'b1;
          slc_RFWriteAddr = is_rtype ? 2'b10 : 2'b01;
          slc_RFWriteData = (kind == K_LW) ? 2'b01 : 2'b00;
          state_next      = S_IF;
        end
        S_HALT: begin
          halted     = 1'b1;
          state_next = S_HALT;
        end
        default: state_next = S_IF;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= S_IF;
      op_q        <= '0;
      func_q      <= '0;
      wait_cnt    <= '0;
      mem_err     <= 1'b0;
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      state <= state_next;
      if (state == S_IF && im_ack) begin
        op_q   <= op_instruction;
        func_q <= func_instruction;
      end
      // Any state change restarts the wait count, so it is zero on entry
      // to IF and MEM; staying put only happens while waiting for an ack.
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if (state == S_IF || state == S_MEM) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout) begin
        mem_err <= 1'b1;
      end
      if (w_pc) begin
        instr_count <= instr_count + 1'b1;
      end
      if (state != S_HALT) begin
        cycle_count <= cycle_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm - directed plus randomized bench for mc_ctrl_fsm.
// Each instruction is expanded into an expected per-cycle trace of control
// outputs built from the instruction's class and its memory wait states.
module tb_mc_ctrl_fsm;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 15;

  // Expected-vector layout, mirrored by obs_v below.
  localparam logic [21:0] M_WPC  = 22'h1 << 21;
  localparam logic [21:0] M_ALUA = 22'h1 << 20;
  localparam logic [21:0] M_ALUB = 22'h1 << 19;
  localparam logic [21:0] M_WRF  = 22'h1 << 18;
  localparam logic [21:0] M_WDM  = 22'h1 << 17;
  localparam logic [21:0] M_IMR  = 22'h1 << 4;
  localparam logic [21:0] M_DMR  = 22'h1 << 3;
  localparam logic [21:0] M_HLT  = 22'h1 << 2;
  localparam logic [21:0] M_ILL  = 22'h1 << 1;
  localparam logic [21:0] M_MERR = 22'h1;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4;
  localparam int C_J = 5, C_JAL = 6, C_JR = 7, C_BAD = 8, C_HALT = 9;

  // {op, func} stimulus table; func is randomized for non-R opcodes.
  localparam logic [11:0] TBL [20] = '{
    {6'b000000, 6'b100000}, {6'b000000, 6'b100010}, {6'b000000, 6'b100100},
    {6'b000000, 6'b100101}, {6'b000000, 6'b101010}, {6'b000000, 6'b001000},
    {6'b001001, 6'b000000}, {6'b001100, 6'b000000}, {6'b001101, 6'b000000},
    {6'b001010, 6'b000000}, {6'b100011, 6'b000000}, {6'b101011, 6'b000000},
    {6'b000100, 6'b000000}, {6'b000101, 6'b000000}, {6'b000010, 6'b000000},
    {6'b000011, 6'b000000}, {6'b000000, 6'b000001}, {6'b000000, 6'b111111},
    {6'b000111, 6'b000000}, {6'b110000, 6'b000000}
  };

  logic             CLK = 1'b0;
  logic             reset;
  logic [5:0]       op_instruction, func_instruction;
  logic             zero, im_ack, dm_ack;
  logic             w_pc, slc_ALUA, slc_ALUB, w_RF, w_dataMem;
  logic [1:0]       slc_RFWriteData, op_ext, slc_pcSrc, slc_RFWriteAddr;
  logic [3:0]       op_ALU;
  logic             im_req, dm_req, halted, mem_err, illegal;
  logic [CNT_W-1:0] instr_count, cycle_count;
  logic [2:0]       state_dbg;
  logic [21:0]      obs_v;

  always #5 CLK = ~CLK;

  mc_ctrl_fsm #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .reset(reset),
    .op_instruction(op_instruction), .func_instruction(func_instruction),
    .zero(zero), .im_ack(im_ack), .dm_ack(dm_ack),
    .w_pc(w_pc), .slc_ALUA(slc_ALUA), .slc_ALUB(slc_ALUB), .w_RF(w_RF),
    .w_dataMem(w_dataMem), .slc_RFWriteData(slc_RFWriteData), .op_ext(op_ext),
    .slc_pcSrc(slc_pcSrc), .slc_RFWriteAddr(slc_RFWriteAddr), .op_ALU(op_ALU),
    .im_req(im_req), .dm_req(dm_req), .halted(halted), .mem_err(mem_err),
    .illegal(illegal), .instr_count(instr_count), .cycle_count(cycle_count),
    .state_dbg(state_dbg)
  );

  assign obs_v = {w_pc, slc_ALUA, slc_ALUB, w_RF, w_dataMem, slc_RFWriteData,
                  op_ext, slc_pcSrc, slc_RFWriteAddr, op_ALU, im_req, dm_req,
                  halted, illegal, mem_err};

  int               errors = 0;
  int               checks = 0;
  logic [21:0]      exp_q[$];
  logic [2:0]       in_q[$];   // {fetch cycle, im_ack, dm_ack}
  logic [5:0]       cur_op, cur_func;
  logic             cur_zero;
  logic [CNT_W-1:0] instr_m, cyc_m;

  function automatic logic [21:0] f_wd(input logic [1:0] v);  return 22'(v) << 15; endfunction
  function automatic logic [21:0] f_ext(input logic [1:0] v); return 22'(v) << 13; endfunction
  function automatic logic [21:0] f_pcs(input logic [1:0] v); return 22'(v) << 11; endfunction
  function automatic logic [21:0] f_wa(input logic [1:0] v);  return 22'(v) << 9;  endfunction
  function automatic logic [21:0] f_alu(input logic [3:0] v); return 22'(v) << 5;  endfunction
  function automatic logic rnd1(); return 1'($urandom_range(0, 1)); endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_instr_count"}, 64'(instr_count), 64'(instr_m));
    chk({tag, "_cycle_count"}, 64'(cycle_count), 64'(cyc_m));
  endtask

  task automatic push(input logic [21:0] e, input logic is_if, input logic ia, input logic da);
    exp_q.push_back(e);
    in_q.push_back({is_if, ia, da});
  endtask

  // Instruction-set table: class and EXE-phase datapath settings.
  function automatic void classify(input logic [5:0] op, input logic [5:0] fn, output int c,
                                   output logic [3:0] alu, output logic alub,
                                   output logic [1:0] ext, output logic is_beq);
    c = C_BAD; alu = 4'b0000; alub = 1'b0; ext = 2'b00; is_beq = 1'b0;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000: begin c = C_R; alu = 4'b0000; end
          6'b100010: begin c = C_R; alu = 4'b0001; end
          6'b100100: begin c = C_R; alu = 4'b0100; end
          6'b100101: begin c = C_R; alu = 4'b0011; end
          6'b101010: begin c = C_R; alu = 4'b0101; end
          6'b001000: c = C_JR;
          default:   c = C_BAD;
        endcase
      end
      6'b001001: begin c = C_I;  alub = 1'b1; ext = 2'b11; alu = 4'b0000; end
      6'b001100: begin c = C_I;  alub = 1'b1; ext = 2'b01; alu = 4'b0100; end
      6'b001101: begin c = C_I;  alub = 1'b1; ext = 2'b01; alu = 4'b0011; end
      6'b001010: begin c = C_I;  alub = 1'b1; ext = 2'b11; alu = 4'b0101; end
      6'b100011: begin c = C_LW; alub = 1'b1; ext = 2'b11; alu = 4'b0000; end
      6'b101011: begin c = C_SW; alub = 1'b1; ext = 2'b11; alu = 4'b0000; end
      6'b000100: begin c = C_BR; ext = 2'b11; alu = 4'b0001; is_beq = 1'b1; end
      6'b000101: begin c = C_BR; ext = 2'b11; alu = 4'b0001; end
      6'b000010: c = C_J;
      6'b000011: c = C_JAL;
      6'b111111: c = C_HALT;
      default:   c = C_BAD;
    endcase
  endfunction

  // Expand one instruction into expected cycles: fetch with imw wait states,
  // decode, then the class-specific EXE/MEM/WB sequence.
  task automatic build_plan(input logic [5:0] op, input logic [5:0] fn,
                            input int imw, input int dmw, input logic z);
    int          c;
    logic [3:0]  alu;
    logic        alub, is_beq, taken;
    logic [1:0]  ext;
    logic [21:0] exe, mem;
    cur_op = op; cur_func = fn; cur_zero = z;
    classify(op, fn, c, alu, alub, ext, is_beq);
    exe = M_ALUA | (alub ? M_ALUB : 22'h0) | f_ext(ext) | f_alu(alu);
    for (int i = 0; i < imw; i++) push(M_IMR, 1'b1, 1'b0, rnd1());
    push(M_IMR, 1'b1, 1'b1, rnd1());
    case (c)
      C_J:    push(M_WPC | f_pcs(2'b11), 1'b0, rnd1(), rnd1());
      C_JAL:  push(M_WPC | f_pcs(2'b11) | M_WRF | f_wa(2'b00) | f_wd(2'b10), 1'b0, rnd1(), rnd1());
      C_JR:   push(M_WPC | f_pcs(2'b10), 1'b0, rnd1(), rnd1());
      C_BAD:  push(M_WPC | M_ILL, 1'b0, rnd1(), rnd1());
      C_HALT: push(22'h0, 1'b0, rnd1(), rnd1());
      default: begin
        push(22'h0, 1'b0, rnd1(), rnd1());
        if (c == C_BR) begin
          taken = is_beq ? z : !z;
          push(exe | M_WPC | f_pcs(taken ? 2'b01 : 2'b00), 1'b0, rnd1(), rnd1());
        end else begin
          push(exe, 1'b0, rnd1(), rnd1());
          if (c == C_LW || c == C_SW) begin
            mem = exe | M_DMR | ((c == C_SW) ? M_WDM : 22'h0);
            for (int i = 0; i < dmw; i++) push(mem, 1'b0, rnd1(), 1'b0);
            push(mem | ((c == C_SW) ? M_WPC : 22'h0), 1'b0, rnd1(), 1'b1);
          end
          if (c != C_SW)
            push(exe | M_WPC | M_WRF | f_wa((c == C_R) ? 2'b10 : 2'b01) |
                 f_wd((c == C_LW) ? 2'b01 : 2'b00), 1'b0, rnd1(), rnd1());
        end
      end
    endcase
  endtask

  // Play up to n planned cycles. Inputs change 1 time unit after the rising
  // edge; outputs are sampled on the falling edge.
  task automatic run_plan(input string tag, input int n);
    logic [21:0] e;
    logic [2:0]  a;
    int          k;
    k = 0;
    while (k < n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = in_q.pop_front();
      if (a[2]) begin
        op_instruction = cur_op; func_instruction = cur_func;
      end else begin
        op_instruction = 6'($urandom); func_instruction = 6'($urandom);
      end
      im_ack = a[1]; dm_ack = a[0]; zero = cur_zero;
      @(negedge CLK);
      chk($sformatf("%s_cyc%0d", tag, k), 64'(obs_v), 64'(e));
      if (!e[2]) cyc_m++;
      if (e[21]) instr_m++;
      @(posedge CLK); #1;
      k++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; im_ack = 1'b1; dm_ack = 1'b1; zero = 1'b0;
    op_instruction = 6'b0; func_instruction = 6'b0;
    exp_q.delete(); in_q.delete();
    instr_m = '0; cyc_m = '0;
    repeat (2) begin
      @(negedge CLK);
      chk("reset_outputs", 64'(obs_v), 64'h0);
      chk("reset_instr_count", 64'(instr_count), 64'h0);
      chk("reset_cycle_count", 64'(cycle_count), 64'h0);
    end
    @(posedge CLK); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [11:0] ent;
    logic [5:0]  op, fn;

    do_reset();

    // add $3,$1,$2 with immediate acks: WB write at cycle 4.
    build_plan(6'b000000, 6'b100000, 0, 0, 1'b0);
    run_plan("add", 100);
    chk_cnt("add");

    // lw with dm_ack three cycles late.
    build_plan(6'b100011, 6'b010101, 0, 3, 1'b0);
    run_plan("lw_wait3", 100);
    chk_cnt("lw_wait3");

    // beq taken, bne not taken.
    build_plan(6'b000100, 6'b000000, 0, 0, 1'b1);
    run_plan("beq_z1", 100);
    build_plan(6'b000101, 6'b000000, 1, 0, 1'b1);
    run_plan("bne_z1", 100);
    chk_cnt("branches");

    build_plan(6'b000011, 6'b000000, 0, 0, 1'b0);
    run_plan("jal", 100);
    build_plan(6'b000000, 6'b000001, 2, 0, 1'b0);
    run_plan("illegal", 100);
    build_plan(6'b101011, 6'b000000, 1, 2, 1'b0);
    run_plan("sw_wait2", 100);
    chk_cnt("directed");

    for (int i = 0; i < 40; i++) begin
      ent = TBL[$urandom_range(0, 19)];
      op  = ent[11:6];
      fn  = (op == 6'b000000) ? ent[5:0] : 6'($urandom);
      build_plan(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), rnd1());
      run_plan($sformatf("rand%0d", i), 100);
      chk_cnt($sformatf("rand%0d", i));
    end

    // Reset in the middle of a waiting sw: strobes drop at once.
    build_plan(6'b101011, 6'b000000, 0, 6, 1'b0);
    run_plan("sw_abort", 4);
    im_ack = 1'b0; dm_ack = 1'b0;
    #1;
    chk("sw_abort_wdm_before", 64'(w_dataMem), 64'h1);
    reset = 1'b1;
    #1;
    chk("sw_abort_wdm_after", 64'(w_dataMem), 64'h0);
    chk("sw_abort_outputs", 64'(obs_v), 64'h0);
    do_reset();

    // im_ack never arrives: watchdog fires on the 15th cycle.
    cur_op = 6'b000000; cur_func = 6'b100000; cur_zero = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) push(M_IMR, 1'b1, 1'b0, rnd1());
    for (int i = 0; i < 4; i++) push(M_HLT | M_MERR, 1'b0, rnd1(), rnd1());
    run_plan("timeout", 100);
    chk_cnt("timeout");
    chk("timeout_cycle_frozen", 64'(cycle_count), 64'(TIMEOUT));
    do_reset();

    // HALT opcode parks the FSM with all controls low.
    build_plan(6'b111111, 6'b000000, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) push(M_HLT, 1'b0, rnd1(), rnd1());
    run_plan("halt", 100);
    chk_cnt("halt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
